// File: rtl/uart_rx_fifo_if.sv
// Consumer-side bundle of the UART receiver: head-of-FIFO entry, flags and flow control.
interface uart_rx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] data;
  logic                  parity_err;
  logic                  frame_err;
  logic                  break_det;
  logic                  valid;
  logic                  ready;
  logic                  overrun;
  logic                  overrun_clr;
  logic [LVL_W-1:0]      fifo_level;

  modport master (
    output data, parity_err, frame_err, break_det, valid, overrun, fifo_level,
    input  ready, overrun_clr
  );

  modport slave (
    input  data, parity_err, frame_err, break_det, valid, overrun, fifo_level,
    output ready, overrun_clr
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with synchroniser, majority filter, mid-bit sampling FSM and a
// first-word fall-through output FIFO carrying per-frame error flags.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           rx_sig,
  uart_rx_fifo_if.master bus
);
  localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
  localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
  localparam int CNT_W            = $clog2(PULSE_WIDTH);
  localparam int PTR_W            = $clog2(FIFO_DEPTH);
  localparam int LVL_W            = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W            = DATA_WIDTH + 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PAR       = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  function automatic logic parity_fail(input logic [DATA_WIDTH-1:0] d, input logic p);
    logic x;
    x = (^d) ^ p;
    return (PARITY == 1) ? x : ~x;
  endfunction

  logic                  r_sync1, r_sync2, r_filt;
  logic [2:0]            r_hist;
  state_t                r_state, w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [3:0]            r_bit;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_err, r_frame_err, r_all_zero;
  logic [ENT_W-1:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0]      r_level;
  logic                  r_overrun;

  logic                  w_tick, w_last_stop, w_push_fe, w_push_bd;
  logic [ENT_W-1:0]      w_entry, w_head;
  logic                  w_valid, w_full, w_pop, w_wr, w_ovf;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_hist  <= 3'b111;
      r_filt  <= 1'b1;
    end else begin
      r_sync1 <= rx_sig;
      r_sync2 <= r_sync1;
      r_hist  <= {r_hist[1:0], r_sync2};
      r_filt  <= maj3(r_hist);
    end
  end

  // The entry pushed on the last stop sample folds in that sample itself.
  assign w_tick      = (r_cnt == CNT_W'(0));
  assign w_last_stop = (r_state == STOP) && w_tick && (r_bit == 4'(STOP_BITS - 1));
  assign w_push_fe   = r_frame_err | ~r_filt;
  assign w_push_bd   = r_all_zero & ~r_filt;
  assign w_entry     = {w_push_bd, w_push_fe, r_par_err, r_shift};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (!r_filt) w_next = START; else w_next = IDLE;
      START:     if (w_tick) w_next = r_filt ? IDLE : DATA; else w_next = START;
      DATA: begin
        if (w_tick && (r_bit == 4'(DATA_WIDTH - 1))) w_next = (PARITY != 0) ? PAR : STOP;
        else                                          w_next = DATA;
      end
      PAR:       if (w_tick) w_next = STOP; else w_next = PAR;
      STOP:      if (w_last_stop) w_next = w_push_fe ? WAIT_HIGH : IDLE; else w_next = STOP;
      WAIT_HIGH: if (r_filt) w_next = IDLE; else w_next = WAIT_HIGH;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt       <= CNT_W'(0);
      r_bit       <= 4'd0;
      r_shift     <= '0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_all_zero  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (!r_filt) r_cnt <= CNT_W'(HALF_PULSE_WIDTH - 1);
        end
        START: begin
          if (w_tick) begin
            r_cnt       <= CNT_W'(PULSE_WIDTH - 1);
            r_bit       <= 4'd0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_all_zero  <= 1'b1;
          end else r_cnt <= r_cnt - CNT_W'(1);
        end
        DATA: begin
          if (w_tick) begin
            r_cnt      <= CNT_W'(PULSE_WIDTH - 1);
            r_shift    <= {r_filt, r_shift[DATA_WIDTH-1:1]};
            r_all_zero <= r_all_zero & ~r_filt;
            r_bit      <= (r_bit == 4'(DATA_WIDTH - 1)) ? 4'd0 : r_bit + 4'd1;
          end else r_cnt <= r_cnt - CNT_W'(1);
        end
        PAR: begin
          if (w_tick) begin
            r_cnt      <= CNT_W'(PULSE_WIDTH - 1);
            r_par_err  <= parity_fail(r_shift, r_filt);
            r_all_zero <= r_all_zero & ~r_filt;
            r_bit      <= 4'd0;
          end else r_cnt <= r_cnt - CNT_W'(1);
        end
        STOP: begin
          if (w_tick) begin
            r_cnt       <= CNT_W'(PULSE_WIDTH - 1);
            r_frame_err <= w_push_fe;
            r_all_zero  <= w_push_bd;
            r_bit       <= r_bit + 4'd1;
          end else r_cnt <= r_cnt - CNT_W'(1);
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign w_valid = (r_level != LVL_W'(0));
  assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_pop   = w_valid & bus.ready;
  assign w_wr    = w_last_stop & (~w_full | w_pop);
  assign w_ovf   = w_last_stop & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr  <= PTR_W'(0);
      r_rd_ptr  <= PTR_W'(0);
      r_level   <= LVL_W'(0);
      r_overrun <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      if (w_ovf)                r_overrun <= 1'b1;
      else if (bus.overrun_clr) r_overrun <= 1'b0;
    end
  end

  // Head fields are forced to zero while empty so reset reads clean.
  assign w_head         = r_mem[r_rd_ptr];
  assign bus.data       = w_valid ? w_head[DATA_WIDTH-1:0] : '0;
  assign bus.parity_err = w_valid & w_head[DATA_WIDTH];
  assign bus.frame_err  = w_valid & w_head[DATA_WIDTH+1];
  assign bus.break_det  = w_valid & w_head[DATA_WIDTH+2];
  assign bus.valid      = w_valid;
  assign bus.overrun    = r_overrun;
  assign bus.fifo_level = r_level;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: even-parity receiver for most cases, odd-parity receiver for the odd frame.
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic rx_e = 1'b1;
  logic rx_o = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [10:0] q_e[$];
  logic [10:0] q_o[$];

  uart_rx_fifo_if #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) ife ();
  uart_rx_fifo_if #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) ifo ();

  uart_rx_fifo #(.DATA_WIDTH(8), .BAUD_RATE(1), .CLK_FREQ(16), .PARITY(1),
                 .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_e (.clk(clk), .rstn(rstn), .rx_sig(rx_e), .bus(ife));

  uart_rx_fifo #(.DATA_WIDTH(8), .BAUD_RATE(1), .CLK_FREQ(16), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_o (.clk(clk), .rstn(rstn), .rx_sig(rx_o), .bus(ifo));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rstn && ife.valid && ife.ready)
      q_e.push_back({ife.break_det, ife.frame_err, ife.parity_err, ife.data});
    if (rstn && ifo.valid && ifo.ready)
      q_o.push_back({ifo.break_det, ifo.frame_err, ifo.parity_err, ifo.data});
  end

  typedef struct {
    logic [7:0]  d;
    logic        p;
    logic        s;
    logic [10:0] exp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic b, input bit sel, input int n);
    if (sel) rx_o = b;
    else     rx_e = b;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input bit sel);
    drive(1'b0, sel, 16);
    for (int i = 0; i < 8; i++) drive(d[i], sel, 16);
    drive(p, sel, 16);
    drive(s, sel, 16);
    drive(1'b1, sel, 20);
  endtask

  initial begin
    vec_t vt[6];
    vt[0] = '{d: 8'hA5, p: 1'b0, s: 1'b1, exp: {3'b000, 8'hA5}};
    vt[1] = '{d: 8'hFF, p: 1'b0, s: 1'b1, exp: {3'b000, 8'hFF}};
    vt[2] = '{d: 8'h81, p: 1'b1, s: 1'b1, exp: {3'b001, 8'h81}};
    vt[3] = '{d: 8'h55, p: 1'b0, s: 1'b0, exp: {3'b010, 8'h55}};
    vt[4] = '{d: 8'h00, p: 1'b0, s: 1'b1, exp: {3'b000, 8'h00}};
    vt[5] = '{d: 8'h07, p: 1'b1, s: 1'b1, exp: {3'b000, 8'h07}};

    ife.ready = 1'b1;
    ife.overrun_clr = 1'b0;
    ifo.ready = 1'b1;
    ifo.overrun_clr = 1'b0;
    repeat (3) tick();
    chk("rst_valid", ife.valid, 1'b0);
    chk("rst_level", ife.fifo_level, 3'd0);
    chk("rst_overrun", ife.overrun, 1'b0);
    chk("rst_data_flags", {ife.break_det, ife.frame_err, ife.parity_err, ife.data}, 11'h000);
    rstn = 1'b1;
    repeat (5) tick();

    for (int i = 0; i < 6; i++) begin
      q_e.delete();
      send_frame(vt[i].d, vt[i].p, vt[i].s, 1'b0);
      chk($sformatf("vec%0d_count", i), q_e.size(), 1);
      chk($sformatf("vec%0d_entry", i), (q_e.size() > 0) ? q_e[0] : 11'h7FF, vt[i].exp);
      chk($sformatf("vec%0d_level", i), ife.fifo_level, 3'd0);
    end

    q_e.delete();
    drive(1'b0, 1'b0, 6);
    drive(1'b1, 1'b0, 40);
    chk("glitch_count", q_e.size(), 0);

    drive(1'b0, 1'b0, 40 * 16);
    drive(1'b1, 1'b0, 40);
    chk("break_count", q_e.size(), 1);
    chk("break_entry", (q_e.size() > 0) ? q_e[0] : 11'h000, {3'b110, 8'h00});

    q_e.delete();
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    chk("after_break_entry", (q_e.size() > 0) ? q_e[0] : 11'h7FF, {3'b000, 8'hA5});

    q_o.delete();
    q_e.delete();
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
    chk("odd_count", q_o.size(), 1);
    chk("odd_entry", (q_o.size() > 0) ? q_o[0] : 11'h000, {3'b001, 8'h3C});
    chk("odd_other_line_quiet", q_e.size(), 0);

    ife.ready = 1'b0;
    q_e.delete();
    for (int k = 1; k <= 5; k++) begin
      logic [7:0] d;
      d = 8'(k);
      send_frame(d, ^d, 1'b1, 1'b0);
    end
    chk("full_level", ife.fifo_level, 3'd4);
    chk("full_overrun", ife.overrun, 1'b1);
    chk("full_head", ife.data, 8'h01);
    chk("full_valid", ife.valid, 1'b1);
    ife.ready = 1'b1;
    repeat (6) tick();
    chk("drain_count", q_e.size(), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("drain%0d", k), (q_e.size() > k) ? q_e[k] : 11'h7FF, {3'b000, 8'(k + 1)});
    chk("drain_level", ife.fifo_level, 3'd0);
    chk("drain_valid", ife.valid, 1'b0);
    chk("overrun_sticky", ife.overrun, 1'b1);
    ife.overrun_clr = 1'b1;
    tick();
    ife.overrun_clr = 1'b0;
    chk("overrun_cleared", ife.overrun, 1'b0);

    ife.ready = 1'b0;
    send_frame(8'h33, 1'b0, 1'b1, 1'b0);
    chk("pre_reset_level", ife.fifo_level, 3'd1);
    drive(1'b0, 1'b0, 16);
    drive(1'b0, 1'b0, 16);
    drive(1'b1, 1'b0, 16);
    drive(1'b0, 1'b0, 16);
    drive(1'b1, 1'b0, 8);
    rstn = 1'b0;
    #1;
    chk("midreset_valid", ife.valid, 1'b0);
    chk("midreset_level", ife.fifo_level, 3'd0);
    chk("midreset_data", ife.data, 8'h00);
    repeat (3) tick();
    rstn = 1'b1;
    drive(1'b1, 1'b0, 200);
    chk("post_reset_no_push", ife.fifo_level, 3'd0);
    ife.ready = 1'b1;
    q_e.delete();
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    chk("post_reset_count", q_e.size(), 1);
    chk("post_reset_entry", (q_e.size() > 0) ? q_e[0] : 11'h7FF, {3'b000, 8'h5A});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
